// File: rtl/spike_sweep_scheduler_pkg.sv
// Shared definitions for the spike sweep scheduler: FSM state encoding and
// the width derivations used by the top, its interface and the comparator.
package spike_sweep_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EVAL = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    // Membrane potential width for a given comparator stage count.
    function automatic int pot_width(input int n_stage);
        return n_stage + 2;
    endfunction

    function automatic int idx_width(input int n_neurons);
        return $clog2(n_neurons);
    endfunction

endpackage

// File: rtl/spike_sweep_scheduler_if.sv
// Potential-memory port and spike-event handshake between the scheduler
// (master) and the memory / spike consumer side (slave).
interface spike_sweep_scheduler_if #(
    parameter int W     = 4,
    parameter int IDX_W = 3
) ();
    logic             mem_rd_en;
    logic [IDX_W-1:0] mem_addr;
    logic [W-1:0]     mem_rd_data;
    logic             mem_wr_en;
    logic [W-1:0]     mem_wr_data;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_idx;
    logic             spike_ready;

    modport master (
        output mem_rd_en, mem_addr, mem_wr_en, mem_wr_data, spike_valid, spike_idx,
        input  mem_rd_data, spike_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, mem_wr_en, mem_wr_data, spike_valid, spike_idx,
        output mem_rd_data, spike_ready
    );
endinterface

// File: rtl/spike_sweep_scheduler_spike_generator.sv
// Threshold comparator: fires when u + minus_theta carries out of W bits,
// which is u >= theta for a non-zero threshold.
module spike_generator
    import spike_sweep_scheduler_pkg::*;
#(
    parameter int n_stage = 2
) (
    input  logic [pot_width(n_stage)-1:0] u,
    input  logic [pot_width(n_stage)-1:0] minus_theta,
    output logic                          is_spike
);
    localparam int W = pot_width(n_stage);

    assign is_spike = 1'(({1'b0, u} + {1'b0, minus_theta}) >> W);
endmodule

// File: rtl/spike_sweep_scheduler.sv
// Sweeps all neuron potentials through one shared comparator, emits a spike
// event per firing neuron and resets that neuron's potential to U_REST.
module spike_sweep_scheduler
    import spike_sweep_scheduler_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int n_stage   = 2,
    parameter int U_REST    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [pot_width(n_stage)-1:0]  theta,
    output logic                           busy,
    output logic                           done,
    output logic [idx_width(N_NEURONS):0]  spike_count,
    spike_sweep_scheduler_if.master        bus
);
    localparam int W     = pot_width(n_stage);
    localparam int IDX_W = idx_width(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     minus_theta;
    logic             is_spike;
    logic             step;

    spike_generator #(.n_stage(n_stage)) u_spike_generator (
        .u           (bus.mem_rd_data),
        .minus_theta (minus_theta),
        .is_spike    (is_spike)
    );

    // A neuron is finished when it did not fire, or when its event was taken.
    assign step = ((state == EVAL) && !is_spike) ||
                  ((state == EMIT) && bus.spike_valid && bus.spike_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            minus_theta     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            spike_count     <= '0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_data <= '0;
            bus.spike_valid <= 1'b0;
            bus.spike_idx   <= '0;
        end else begin
            // NOTE: strobes default low here so each one is a single-cycle pulse
            // unless the state below re-asserts it; later assignments win.
            done            <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_data <= W'(U_REST);

            case (state)
                IDLE: begin
                    if (start) begin
                        minus_theta   <= ~theta + W'(1);
                        idx           <= '0;
                        spike_count   <= '0;
                        busy          <= 1'b1;
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= '0;
                        state         <= READ;
                    end
                end
                READ: state <= EVAL;
                EVAL: begin
                    if (is_spike) begin
                        bus.spike_idx   <= idx;
                        bus.spike_valid <= 1'b1;
                        bus.mem_wr_en   <= 1'b1;
                        bus.mem_addr    <= idx;
                        spike_count     <= spike_count + (IDX_W + 1)'(1);
                        state           <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.spike_ready) bus.spike_valid <= 1'b0;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (step) begin
                if (idx == LAST_IDX) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    idx           <= idx + IDX_W'(1);
                    bus.mem_rd_en <= 1'b1;
                    bus.mem_addr  <= idx + IDX_W'(1);
                    state         <= READ;
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_sweep_scheduler.sv
// Directed bench: behavioural potential memory, spike consumer with ready
// stalls, and hand-computed expectations for each sweep.
module tb_spike_sweep_scheduler;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] theta;
    logic       busy;
    logic       done;
    logic [3:0] spike_count;

    spike_sweep_scheduler_if #(.W(4), .IDX_W(3)) bus ();

    spike_sweep_scheduler #(.N_NEURONS(8), .n_stage(2), .U_REST(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .theta       (theta),
        .busy        (busy),
        .done        (done),
        .spike_count (spike_count),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] mem [8];
    logic       rd_pend;
    logic [2:0] rd_addr;

    // Per-sweep observations
    logic [7:0] spk_mask, wr_mask;
    int         spk_n, wr_n, rd_n, first_rd_addr, done_cyc, max_run;
    logic       overlap, busy_bad, idx_unstable;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] out_vec();
        return {13'd0, busy, done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr,
                bus.mem_wr_data, bus.spike_valid, bus.spike_idx, spike_count};
    endfunction

    function automatic logic [31:0] mem_vec();
        return {mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
    endfunction

    task automatic load(input logic [31:0] pots);
        for (int i = 0; i < 8; i++) mem[i] = pots[4*i +: 4];
    endtask

    // Memory model: read data appears the cycle after the strobe, writes land
    // at the end of the strobe cycle.
    task automatic mem_step();
        if (rd_pend) bus.mem_rd_data = mem[rd_addr];
        rd_pend = bus.mem_rd_en;
        rd_addr = bus.mem_addr;
        if (bus.mem_rd_en) begin
            if (rd_n == 0) first_rd_addr = int'(bus.mem_addr);
            rd_n++;
        end
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] = bus.mem_wr_data;
            wr_mask = wr_mask | (8'd1 << bus.mem_addr);
            wr_n++;
        end
        if (bus.mem_rd_en && bus.mem_wr_en) overlap = 1'b1;
    endtask

    task automatic clear_stats();
        spk_mask = '0; wr_mask = '0;
        spk_n = 0; wr_n = 0; rd_n = 0; first_rd_addr = -1; done_cyc = -1; max_run = 0;
        overlap = 1'b0; busy_bad = 1'b0; idx_unstable = 1'b0; rd_pend = 1'b0;
    endtask

    // Pulses start at cycle 0 and runs until done (bounded); hold stalls ready
    // for that many valid cycles, mid_cyc re-pulses start with theta=1.
    task automatic run_sweep(input logic [3:0] th, input int hold, input int mid_cyc);
        int         cyc;
        int         hold_left;
        int         run;
        logic [2:0] held_idx;
        clear_stats();
        hold_left = hold;
        run = 0;
        held_idx = '0;
        theta = th;
        start = 1'b1;
        tick();
        start = 1'b0;
        theta = 4'd0;
        cyc = 1;
        while (cyc < 200 && done_cyc < 0) begin
            mem_step();
            if (!busy) busy_bad = 1'b1;
            if (bus.spike_valid) begin
                if (run == 0) held_idx = bus.spike_idx;
                else if (bus.spike_idx != held_idx) idx_unstable = 1'b1;
                run++;
                if (hold_left > 0) begin
                    bus.spike_ready = 1'b0;
                    hold_left--;
                end else begin
                    bus.spike_ready = 1'b1;
                    spk_mask = spk_mask | (8'd1 << bus.spike_idx);
                    spk_n++;
                    if (run > max_run) max_run = run;
                    run = 0;
                end
            end else begin
                bus.spike_ready = 1'b1;
            end
            if (cyc == mid_cyc) begin
                start = 1'b1;
                theta = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (done) done_cyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        tick();
        check("done_one_cycle", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        theta = 4'd0;
        bus.spike_ready = 1'b1;
        bus.mem_rd_data = 4'd0;
        clear_stats();
        load(32'h0);
        tick();
        check("reset_outputs", out_vec(), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_outputs", out_vec(), 32'd0);

        // Mixed potentials, theta=5: fires on 5, 6, 15, 5 at idx 2, 3, 4, 6.
        load({4'd1, 4'd5, 4'd3, 4'd15, 4'd6, 4'd5, 4'd4, 4'd0});
        run_sweep(4'd5, 0, -1);
        check("t1_done_cycle", 32'(done_cyc), 32'd21);
        check("t1_spike_mask", 32'(spk_mask), 32'h5c);
        check("t1_spike_n", 32'(spk_n), 32'd4);
        check("t1_write_mask", 32'(wr_mask), 32'h5c);
        check("t1_mem_after", mem_vec(), 32'h1030_0040);
        check("t1_count", 32'(spike_count), 32'd4);
        check("t1_rd_wr_overlap", 32'(overlap), 32'd0);
        check("t1_busy_held", 32'(busy_bad), 32'd0);
        repeat (3) tick();
        check("t1_count_holds", 32'(spike_count), 32'd4);

        // theta=0 disables spiking even for full-scale potentials.
        load(32'hffff_ffff);
        run_sweep(4'd0, 0, -1);
        check("t2_done_cycle", 32'(done_cyc), 32'd17);
        check("t2_spike_n", 32'(spk_n), 32'd0);
        check("t2_write_n", 32'(wr_n), 32'd0);
        check("t2_count", 32'(spike_count), 32'd0);

        // theta=15: only 15 carries (15+1=16); 14 stays below.
        load({4'd15, 4'd2, 4'd1, 4'd13, 4'd8, 4'd7, 4'd0, 4'd14});
        run_sweep(4'd15, 0, -1);
        check("t3_done_cycle", 32'(done_cyc), 32'd18);
        check("t3_spike_mask", 32'(spk_mask), 32'h80);
        check("t3_count", 32'(spike_count), 32'd1);

        // Consumer stalls 5 cycles on the idx 1 event.
        load({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0});
        run_sweep(4'd5, 5, -1);
        check("t4_valid_cycles", 32'(max_run), 32'd6);
        check("t4_idx_stable", 32'(idx_unstable), 32'd0);
        check("t4_spike_mask", 32'(spk_mask), 32'h02);
        check("t4_write_pulses", 32'(wr_n), 32'd1);
        check("t4_done_cycle", 32'(done_cyc), 32'd23);
        check("t4_mem_after", mem_vec(), 32'h0);

        // start with theta=1 mid-sweep must not replace the latched theta=8.
        load({4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd9, 4'd1, 4'd8});
        run_sweep(4'd8, 0, 5);
        check("t5_spike_mask", 32'(spk_mask), 32'h05);
        check("t5_count", 32'(spike_count), 32'd2);
        check("t5_done_cycle", 32'(done_cyc), 32'd19);

        // Reset while an event is pending aborts the sweep cleanly.
        load({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0, 4'd0});
        clear_stats();
        theta = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.spike_ready = 1'b0;
        for (int i = 0; i < 50 && !bus.spike_valid; i++) begin
            mem_step();
            tick();
        end
        check("t6_in_emit", 32'({bus.spike_valid, bus.spike_idx}), 32'h0a);
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", out_vec(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || out_vec() != 32'd0) check("t6_reset_quiet", out_vec(), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        bus.spike_ready = 1'b1;
        tick();
        check("t6_after_reset", out_vec(), 32'd0);
        load({4'd0, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
        run_sweep(4'd5, 0, -1);
        check("t6_first_read_addr", 32'(first_rd_addr), 32'd0);
        check("t6_reads", 32'(rd_n), 32'd8);
        check("t6_spike_mask", 32'(spk_mask), 32'h20);
        check("t6_done_cycle", 32'(done_cyc), 32'd18);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spike_sweep_scheduler.md
# spike_sweep_scheduler

Time-multiplexed controller that shares one threshold comparator (the team's `spike_generator` adder-sign check) across `N_NEURONS` membrane potentials held in an external single-port-read potential memory. On each `start` it sweeps neuron indices 0..N-1, reads each potential, tests it against a latched threshold, emits a spike event through a valid/ready handshake, and writes the rest potential back for every neuron that fired. It sits between the neuron state memory and the spike output/router logic in the core's update loop.

## Interface
- `N_NEURONS`, 8, number of neurons swept; ≥2.
- `n_stage`, 2, comparator stage parameter; potential width `W = n_stage+2`.
- `U_REST`, 0, W-bit value written back to a neuron that fired.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a sweep when idle.
- `theta`  in  W  unsigned threshold; sampled on accepted `start`.
- `mem_rd_en`  out  1  potential read strobe.
- `mem_addr`  out  clog2(N_NEURONS)  read/write index.
- `mem_rd_data`  in  W  potential, valid the cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  one-cycle write strobe.
- `mem_wr_data`  out  W  always `U_REST`.
- `spike_valid`  out  1  spike event pending.
- `spike_idx`  out  clog2(N_NEURONS)  index of spiking neuron.
- `spike_ready`  in  1  consumer accepts event.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at sweep end.
- `spike_count`  out  clog2(N_NEURONS)+1  spikes in last sweep; holds until next accepted `start`.

## Operation
- States: IDLE, READ, EVAL, EMIT, DONE.
- IDLE: `start`=1 → latch `minus_theta = (~theta + 1) mod 2^W`, idx=0, `spike_count`=0, `busy`=1 → READ.
- READ: `mem_rd_en`=1, `mem_addr`=idx → EVAL.
- EVAL: spike = carry-out of the (W+1)-bit sum `mem_rd_data + minus_theta`, i.e. `u ≥ theta`. theta=0 gives minus_theta=0, so carry is never set: theta=0 disables spiking (decided). Spike → register `spike_idx`=idx, increment `spike_count` → EMIT. No spike: idx==N-1 → DONE, else idx+1 → READ.
- EMIT: `spike_valid`=1; first EMIT cycle only: `mem_wr_en`=1, `mem_addr`=`spike_idx`. Stay until `spike_valid && spike_ready`; on that cycle, idx==N-1 → DONE, else idx+1 → READ.
- DONE: `done`=1 for one cycle, `busy`=0 next cycle → IDLE.
- `start` while not IDLE: ignored, no effect on `theta` latch.
- `spike_idx` stable while `spike_valid`=1; `spike_valid` never drops without a handshake.
- All outputs registered.

## Timing
- Reset (any state, async): state IDLE; all outputs 0; `spike_count`=0; sweep aborted, no `done`, no pending write.
- `start` at cycle 0 → `mem_rd_en` at cycle 1, first EVAL at cycle 2.
- Non-spiking neuron: 2 cycles. Spiking neuron: 2 + k cycles (k ≥ 1 EMIT cycles; `spike_ready` held high → k=1).
- Full sweep, no spikes: `done` at cycle 2N+1 after `start`; with S spikes and ready held high: 2N+S+1.
- `spike_ready` high before `spike_valid`: accepted on the first EMIT cycle.
- `mem_rd_en` and `mem_wr_en` never asserted in the same cycle.

## Structure
- Shared package: state encoding, `W`, `IDX_W = clog2(N_NEURONS)` derivation.
- One sub-module instance: `spike_generator #(n_stage)` fed `mem_rd_data` and latched `minus_theta`; its `is_spike` is the EVAL decision. No other arithmetic on the compare path.

## Test plan
- W=4, N=8, theta=5, potentials {0,4,5,6,15,3,5,1}, ready=1 → spikes idx 2,3,4,6; writes 0 to those; `spike_count`=4; `done` at cycle 2·8+4+1=21.
- theta=0, potentials all 15 → no spikes, no writes, `spike_count`=0, `done` at cycle 17.
- theta=15, potential 15 at idx 7 only → single spike idx 7 (wrap boundary 15+1=16 carry), then DONE.
- Spike at idx 1, ready held low 5 cycles → `spike_valid` and `spike_idx`=1 stable 6 cycles, single `mem_wr_en` pulse, sweep resumes after handshake.
- `start` pulsed mid-sweep with theta=1 → ignored; comparisons still use first-latched theta.
- `rst_n` low during EMIT → all outputs 0 immediately; no `done`; next `start` runs a clean sweep from idx 0.
